fractal_sync_mp_rx: RTL and testbench

FRACTAL_SYNC_MP_RX -- requirements
Module: fractal_sync_mp_rx

---
 rtl/fractal_sync_mp_rx.sv | 164 ++++++++++++++++
 tb/tb_fractal_sync_mp_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_mp_rx.sv
// Multi-port fractal-sync receiver: per-port sampling, local/root decode, per-port FIFOs, round-robin output.
// Optional macro FRACTAL_SYNC_MP_RX_OCCUPANCY_EN enables the live per-port occupancy counters.
module fractal_sync_mp_rx #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned AGGR_W     = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned COMB_IN    = 0,
  localparam int unsigned PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_PORTS-1:0]          req_sync_i,
  input  logic [N_PORTS*AGGR_W-1:0]   req_aggr_i,
  input  logic [N_PORTS*ID_W-1:0]     req_id_i,
  output logic [N_PORTS-1:0]          check_propagate_o,
  output logic [N_PORTS-1:0]          local_o,
  output logic [N_PORTS-1:0]          root_o,
  output logic [N_PORTS-1:0]          error_overflow_o,
  input  logic [N_PORTS-1:0]          clear_err_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [AGGR_W-2:0]           aggr_o,
  output logic [ID_W-1:0]             id_o,
  output logic [PORT_W-1:0]           port_o,
  output logic [N_PORTS*CNT_W-1:0]    occupancy_o
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = AGGR_W - 1 + ID_W;

  logic [N_PORTS-1:0]        s_sync;
  logic [N_PORTS*AGGR_W-1:0] s_aggr;
  logic [N_PORTS*ID_W-1:0]   s_id;
  logic [N_PORTS-1:0]        nonempty;
  logic [N_PORTS*ENT_W-1:0]  head_flat;
  logic [PORT_W-1:0]         grant, search, hold_idx_q, rr_ptr;
  logic                      hold_q, xfer;

  generate
    if (COMB_IN != 0) begin : g_comb_in
      assign s_sync = req_sync_i;
      assign s_aggr = req_aggr_i;
      assign s_id   = req_id_i;
    end else begin : g_reg_in
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          s_sync <= '0;
          s_aggr <= '0;
          s_id   <= '0;
        end else begin
          s_sync <= req_sync_i;
          for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (req_sync_i[p]) begin
              s_aggr[p*AGGR_W +: AGGR_W] <= req_aggr_i[p*AGGR_W +: AGGR_W];
              s_id[p*ID_W +: ID_W]       <= req_id_i[p*ID_W +: ID_W];
            end
          end
        end
      end
    end
  endgenerate

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [AGGR_W-1:0]     aggr;
    logic [ID_W-1:0]       id;
    logic                  push, pop, full, accept, ovf;
    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld, vld_nxt;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    assign aggr   = s_aggr[p*AGGR_W +: AGGR_W];
    assign id     = s_id[p*ID_W +: ID_W];
    assign check_propagate_o[p] = s_sync[p];
    assign local_o[p]  = s_sync[p] & aggr[0];
    assign root_o[p]   = (aggr == AGGR_W'(1));
    assign push   = s_sync[p] & ~aggr[0];
    assign full   = &vld;
    assign pop    = xfer && (grant == PORT_W'(p));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign accept = push & (~full | pop);
    assign ovf    = push & full & ~pop;
    assign nonempty[p] = |vld;
    assign head_flat[p*ENT_W +: ENT_W] = mem[rd_ptr];

    always_comb begin
      vld_nxt = vld;
      if (pop)    vld_nxt[rd_ptr] = 1'b0;
      if (accept) vld_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (accept) mem[wr_ptr] <= {aggr[AGGR_W-1:1], id};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        error_overflow_o[p] <= 1'b0;
      end else begin
        vld <= vld_nxt;
        if (accept) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)    rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (ovf)                 error_overflow_o[p] <= 1'b1;
        else if (clear_err_i[p]) error_overflow_o[p] <= 1'b0;
      end
    end

`ifdef FRACTAL_SYNC_MP_RX_OCCUPANCY_EN
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           count <= '0;
      else if (accept & ~pop) count <= count + 1'b1;
      else if (pop & ~accept) count <= count - 1'b1;
    end
    assign occupancy_o[p*CNT_W +: CNT_W] = count;
`else
    assign occupancy_o[p*CNT_W +: CNT_W] = '0;
`endif
  end

  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    search = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = (32'(rr_ptr) + i) % N_PORTS;
      if (!found && nonempty[PORT_W'(idx)]) begin
        found  = 1'b1;
        search = PORT_W'(idx);
      end
    end
  end

  // A stalled grant is latched so later arrivals on other ports cannot steal the output.
  assign grant   = hold_q ? hold_idx_q : search;
  assign valid_o = |nonempty;
  assign xfer    = valid_o & ready_i;

  always_comb begin
    {aggr_o, id_o} = '0;
    port_o         = '0;
    if (valid_o) begin
      {aggr_o, id_o} = head_flat[32'(grant)*ENT_W +: ENT_W];
      port_o         = grant;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      if (xfer) rr_ptr <= (grant == PORT_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
      hold_q     <= valid_o & ~ready_i;
      hold_idx_q <= grant;
    end
  end
endmodule

// File: tb/tb_fractal_sync_mp_rx.sv
// Directed self-checking bench for fractal_sync_mp_rx at default parameters (4 ports, depth 2, registered input).
module tb_fractal_sync_mp_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_sync = '0;
  logic [15:0] req_aggr = '0;
  logic [7:0]  req_id = '0;
  logic [3:0]  check_propagate, local_s, root_s, err, clear_err = '0;
  logic        valid, ready = 1'b0;
  logic [2:0]  aggr;
  logic [1:0]  id, port;
  logic [7:0]  occupancy;
  int unsigned n_cmp = 0, n_bad = 0;

`ifdef FRACTAL_SYNC_MP_RX_OCCUPANCY_EN
  localparam logic [1:0] OCC_FULL = 2'd2;
`else
  localparam logic [1:0] OCC_FULL = 2'd0;
`endif

  fractal_sync_mp_rx #(.N_PORTS(4), .AGGR_W(4), .ID_W(2), .FIFO_DEPTH(2), .COMB_IN(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_sync_i(req_sync), .req_aggr_i(req_aggr), .req_id_i(req_id),
    .check_propagate_o(check_propagate), .local_o(local_s), .root_o(root_s),
    .error_overflow_o(err), .clear_err_i(clear_err), .valid_o(valid), .ready_i(ready),
    .aggr_o(aggr), .id_o(id), .port_o(port), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] a, input logic [1:0] i);
    req_sync[p] = 1'b1;
    req_aggr[p*4 +: 4] = a;
    req_id[p*2 +: 2] = i;
  endtask

  task automatic do_reset();
    req_sync = '0; clear_err = '0; ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if ({err, check_propagate, occupancy} !== 16'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", {err, check_propagate, occupancy}); end
    n_cmp++; if ({aggr, id, port} !== 7'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", {aggr, id, port}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    drive(0, 4'b0110, 2'd2);
    tick();
    req_sync = '0;
    n_cmp++; if (check_propagate !== 4'b0001) begin n_bad++; $display("FAIL single_cp: got %b want 0001", check_propagate); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", valid); end
    tick();
    n_cmp++; if ({valid, aggr, id, port} !== {1'b1, 3'b011, 2'd2, 2'd0}) begin n_bad++; $display("FAIL single_out: got %b want 1011%b%b", {valid, aggr, id, port}, 2'd2, 2'd0); end
    n_cmp++; if (check_propagate !== 4'b0000) begin n_bad++; $display("FAIL single_cp_drop: got %b want 0000", check_propagate); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_once[%0d]: got %b want 0", k, valid); end
    end
  endtask

  task automatic test_local_root();
    do_reset();
    ready = 1'b1;
    drive(1, 4'b0001, 2'd1);
    tick();
    req_sync = '0;
    n_cmp++; if ({local_s, root_s} !== 8'b0010_0010) begin n_bad++; $display("FAIL local_root: got %b want 00100010", {local_s, root_s}); end
    tick();
    n_cmp++; if ({local_s, root_s, valid} !== 9'b0000_0010_0) begin n_bad++; $display("FAIL root_hold: got %b want 000000100", {local_s, root_s, valid}); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL local_no_push: got %b want 0", valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ready = 1'b1;
    for (int p = 0; p < 4; p++) drive(p, 4'b0010, 2'(p));
    tick();
    req_sync = '0;
    tick();
    for (int p = 0; p < 4; p++) begin
      n_cmp++; if ({valid, aggr, id, port} !== {1'b1, 3'b001, 2'(p), 2'(p)}) begin n_bad++; $display("FAIL rr[%0d]: got %b want 1001%b%b", p, {valid, aggr, id, port}, 2'(p), 2'(p)); end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty: got %b want 0", valid); end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    drive(2, 4'b0100, 2'd3);
    tick();
    req_sync = '0;
    tick();
    drive(0, 4'b0010, 2'd1);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({valid, aggr, id, port} !== {1'b1, 3'b010, 2'd3, 2'd2}) begin n_bad++; $display("FAIL stall_hold[%0d]: got %b want 10101110", k, {valid, aggr, id, port}); end
      tick();
      req_sync = '0;
    end
    ready = 1'b1;
    tick();
    n_cmp++; if ({valid, aggr, id, port} !== {1'b1, 3'b001, 2'd1, 2'd0}) begin n_bad++; $display("FAIL stall_next: got %b want 10010100", {valid, aggr, id, port}); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty: got %b want 0", valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(3, 4'b0100, 2'(k));
      tick();
    end
    req_sync = '0;
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL ovf_early: got %b want 0000", err); end
    tick();
    n_cmp++; if (err !== 4'b1000) begin n_bad++; $display("FAIL ovf_flag: got %b want 1000", err); end
    n_cmp++; if (occupancy[7:6] !== OCC_FULL) begin n_bad++; $display("FAIL ovf_occ: got %0d want %0d", occupancy[7:6], OCC_FULL); end
    ready = 1'b1;
    n_cmp++; if ({valid, id, port} !== 5'b1_01_11) begin n_bad++; $display("FAIL drain0: got %b want 10111", {valid, id, port}); end
    tick();
    n_cmp++; if ({valid, id, port} !== 5'b1_10_11) begin n_bad++; $display("FAIL drain1: got %b want 11011", {valid, id, port}); end
    tick();
    n_cmp++; if ({valid, err} !== 5'b0_1000) begin n_bad++; $display("FAIL drain_end: got %b want 01000", {valid, err}); end
    clear_err[3] = 1'b1;
    tick();
    clear_err = '0;
    n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL ovf_clear: got %b want 0000", err); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 4'b0110, 2'(k));
      tick();
    end
    req_sync = '0;
    ready = 1'b1;
    tick();
    n_cmp++; if ({valid, aggr, id, port, err} !== {1'b1, 3'b011, 2'd2, 2'd1, 4'b0}) begin n_bad++; $display("FAIL fpp_head: got %b want 101110010000", {valid, aggr, id, port, err}); end
    n_cmp++; if (occupancy[3:2] !== OCC_FULL) begin n_bad++; $display("FAIL fpp_occ: got %0d want %0d", occupancy[3:2], OCC_FULL); end
    tick();
    n_cmp++; if ({valid, id, port} !== 5'b1_11_01) begin n_bad++; $display("FAIL fpp_third: got %b want 11101", {valid, id, port}); end
    tick();
    n_cmp++; if ({valid, err} !== 5'b0) begin n_bad++; $display("FAIL fpp_end: got %b want 00000", {valid, err}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 3; p++) drive(p, 4'b0100, 2'(p));
    tick();
    req_sync = '0;
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %b want 1", valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({valid, occupancy} !== 9'h0) begin n_bad++; $display("FAIL mid_async: got %h want 0", {valid, occupancy}); end
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_idle[%0d]: got %b want 0", k, valid); end
    end
    drive(1, 4'b1000, 2'd2);
    tick();
    req_sync = '0;
    tick();
    n_cmp++; if ({valid, aggr, id, port} !== {1'b1, 3'b100, 2'd2, 2'd1}) begin n_bad++; $display("FAIL mid_new: got %b want 11001001", {valid, aggr, id, port}); end
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_local_root();
    test_round_robin();
    test_back_to_back_stall();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
